// File: rtl/async_fifo_reader.sv
// ============================================================================
// async_fifo_reader
// ----------------------------------------------------------------------------
// Read-side drain controller for the async FIFO. Everything in this module runs
// in the read clock domain. The block watches the FIFO empty flag and pulses
// r_Inc to pop the FIFO. It packs words_Per_Beat consecutive words into one wide
// beat and offers that beat downstream on a valid/ready handshake. Popping stops
// while downstream applies back-pressure.
//
// Optional feature (compile-time macro READ_CHECK_EN):
//   When defined, every popped word is compared with an expected incrementing
//   count. A mismatch sets the sticky seq_Err flag.
//   When undefined, there is no expectation register and seq_Err is tied low.
//
// Parameters
//   data_Size       width of one FIFO word
//   words_Per_Beat  FIFO words packed per output beat (must be >= 2)
//   cnt_Size        width of beat_Count
//
// Ports
//   r_Clk       in   read clock
//   r_Rst       in   asynchronous, active-high reset
//   fifo_Empty  in   FIFO empty flag, already synchronised to r_Clk
//   read_Data   in   FIFO head word, valid while fifo_Empty=0
//   r_Inc       out  pop strobe to the FIFO
//   flush       in   synchronous discard of the partial and the presented beat
//   out_Data    out  packed beat; the first popped word sits in lane 0 (LSBs)
//   out_Valid   out  beat available
//   out_Ready   in   downstream accepts the beat
//   beat_Count  out  number of beats accepted downstream; wraps around
//   seq_Err     out  sticky sequence-check error
// ============================================================================
module async_fifo_reader #(
    parameter int data_Size      = 8,
    parameter int words_Per_Beat = 4,
    parameter int cnt_Size       = 16
) (
    input  logic                                r_Clk,
    input  logic                                r_Rst,
    input  logic                                fifo_Empty,
    input  logic [data_Size-1:0]                read_Data,
    output logic                                r_Inc,
    input  logic                                flush,
    output logic [data_Size*words_Per_Beat-1:0] out_Data,
    output logic                                out_Valid,
    input  logic                                out_Ready,
    output logic [cnt_Size-1:0]                 beat_Count,
    output logic                                seq_Err
);

    localparam int BW = data_Size * words_Per_Beat;
    localparam int CW = (words_Per_Beat > 2) ? $clog2(words_Per_Beat) : 1;
    localparam int NL = words_Per_Beat - 1;   // lanes held in the accumulator
    localparam logic [CW-1:0] LAST = CW'(words_Per_Beat - 1);

    typedef enum logic {
        ACCUM   = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [data_Size-1:0] acc_q [NL];
    logic [BW-1:0]        out_data_q;
    logic [cnt_Size-1:0]  beat_cnt_q;

    logic                 valid_w;
    logic                 pop;
    logic                 last_pop;
    logic                 accept;
    logic [NL-1:0]        lane_we;
    logic [BW-1:0]        beat_d;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign pop      = r_Inc;
    assign last_pop = pop && (cnt_q == LAST);
    // A flush in the same cycle discards the presented beat, so the beat
    // does not count as accepted.
    assign accept   = valid_w && out_Ready && !flush;

    // ------------------------------------------------------------------
    // Lane write enables and the beat image assembled from the accumulator
    // plus the word being popped this cycle. The completing word goes
    // straight into the top lane, so the final pop has zero extra latency.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_lane
            assign lane_we[gi] = pop && (cnt_q == CW'(gi));
            assign beat_d[gi*data_Size +: data_Size] = acc_q[gi];
        end
    endgenerate
    assign beat_d[NL*data_Size +: data_Size] = read_Data;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge r_Clk or posedge r_Rst) begin
        if (r_Rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (last_pop) begin
                        state_d = PRESENT;
                    end
                end
                PRESENT: begin
                    // A completing pop while the current beat is taken
                    // refills the output, so beats go back-to-back.
                    if (out_Ready) begin
                        state_d = last_pop ? PRESENT : ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // Popping is allowed only when the output register is free or is being
    // drained this cycle. Reset and flush both block the pop at once, so
    // no word is lost during reset or flush.
    // ------------------------------------------------------------------
    always_comb begin
        valid_w = (state_q == PRESENT);
        r_Inc   = !r_Rst && !flush && !fifo_Empty && (!valid_w || out_Ready);
    end

    // ------------------------------------------------------------------
    // Word counter within the current beat
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (pop) begin
            cnt_d = last_pop ? '0 : (cnt_q + CW'(1));
        end
    end

    always_ff @(posedge r_Clk or posedge r_Rst) begin
        if (r_Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Partial-beat accumulator. Stale lanes left behind by a flush are
    // harmless because every lane is rewritten before the next completing
    // pop reads it.
    // ------------------------------------------------------------------
    always_ff @(posedge r_Clk or posedge r_Rst) begin
        if (r_Rst) begin
            for (int i = 0; i < NL; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (lane_we[i]) begin
                    acc_q[i] <= read_Data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output beat register. It loads only on a completing pop. In PRESENT
    // with out_Ready low no pop can happen, so the data stays stable.
    // ------------------------------------------------------------------
    always_ff @(posedge r_Clk or posedge r_Rst) begin
        if (r_Rst) begin
            out_data_q <= '0;
        end else if (last_pop) begin
            out_data_q <= beat_d;
        end
    end

    // ------------------------------------------------------------------
    // Accepted-beat counter. It wraps naturally and survives a flush.
    // ------------------------------------------------------------------
    always_ff @(posedge r_Clk or posedge r_Rst) begin
        if (r_Rst) begin
            beat_cnt_q <= '0;
        end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + cnt_Size'(1);
        end
    end

    assign out_Data   = out_data_q;
    assign out_Valid  = valid_w;
    assign beat_Count = beat_cnt_q;

    // ------------------------------------------------------------------
    // Optional sequence checker. The expectation always follows the last
    // popped word, so after one bad word the checker resynchronises and
    // does not flag every later word.
    // ------------------------------------------------------------------
`ifdef READ_CHECK_EN
    logic [data_Size-1:0] exp_q;
    logic                 seq_err_q;

    always_ff @(posedge r_Clk or posedge r_Rst) begin
        if (r_Rst) begin
            exp_q     <= '0;
            seq_err_q <= 1'b0;
        end else if (pop) begin
            exp_q <= read_Data + data_Size'(1);
            if (read_Data != exp_q) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    assign seq_Err = seq_err_q;
`else
    assign seq_Err = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_reader.sv
module tb_async_fifo_reader;

    logic        r_Clk;
    logic        r_Rst;
    logic        fifo_Empty;
    logic [7:0]  read_Data;
    logic        r_Inc;
    logic        flush;
    logic [31:0] out_Data;
    logic        out_Valid;
    logic        out_Ready;
    logic [15:0] beat_Count;
    logic        seq_Err;

    int checks   = 0;
    int failures = 0;

    // Behavioural FIFO: the initial block writes words and the monitor pops.
    logic [7:0]  mem [0:63];
    logic [5:0]  wr_ptr = '0;
    logic [5:0]  rd_ptr = '0;
    logic        empty_gate;

    logic [31:0] sb [$];

    logic        hold_prev = 1'b0;
    logic [31:0] hold_data = '0;
    logic        pend      = 1'b0;
    logic [31:0] exp_beat;
    logic [5:0]  r0;

`ifdef READ_CHECK_EN
    localparam logic SE = 1'b1;
`else
    localparam logic SE = 1'b0;
`endif

    assign fifo_Empty = empty_gate | (rd_ptr == wr_ptr);
    assign read_Data  = mem[rd_ptr];

    async_fifo_reader #(.data_Size(8), .words_Per_Beat(4), .cnt_Size(16)) dut (
        .r_Clk     (r_Clk),
        .r_Rst     (r_Rst),
        .fifo_Empty(fifo_Empty),
        .read_Data (read_Data),
        .r_Inc     (r_Inc),
        .flush     (flush),
        .out_Data  (out_Data),
        .out_Valid (out_Valid),
        .out_Ready (out_Ready),
        .beat_Count(beat_Count),
        .seq_Err   (seq_Err)
    );

    initial begin
        r_Clk = 1'b0;
        forever #5 r_Clk = ~r_Clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge r_Clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic push_beat(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        push(b0); push(b1); push(b2); push(b3);
        sb.push_back({b3, b2, b1, b0});
    endtask

    task automatic wait_sb(input string tag);
        for (int k = 0; k < 60 && sb.size() != 0; k++) step();
        chk(tag, sb.size(), 0);
    endtask

    task automatic do_reset();
        empty_gate = 1'b1;
        step();
        r_Rst = 1'b1;
        step();
        step();
        r_Rst = 1'b0;
        step();
    endtask

    // Monitor: scoreboard compare on every handshake, stability under
    // back-pressure, no pop while empty, and the FIFO read pointer update.
    always begin
        @(negedge r_Clk);
        #3;
        if (!r_Rst) begin
            chk("no_pop_when_empty", r_Inc & fifo_Empty, 0);
            if (hold_prev) begin
                chk("hold_valid", out_Valid, 1);
                chk("hold_data", out_Data, hold_data);
            end
            if (out_Valid && out_Ready && !flush) begin
                chk("beat_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_beat = sb.pop_front();
                    chk("beat_data", out_Data, exp_beat);
                    $display("beat out_Data=%08h expected=%08h beat_Count=%0d",
                             out_Data, exp_beat, beat_Count);
                end
            end
            hold_prev = out_Valid && !out_Ready && !flush;
            hold_data = out_Data;
        end else begin
            hold_prev = 1'b0;
        end
        pend = r_Inc;
        @(posedge r_Clk);
        #1;
        if (pend) rd_ptr = rd_ptr + 6'd1;
    end

    initial begin
        r_Rst      = 1'b1;
        empty_gate = 1'b1;
        out_Ready  = 1'b0;
        flush      = 1'b0;
        step();
        step();
        chk("rst_r_inc", r_Inc, 0);
        chk("rst_valid", out_Valid, 0);
        chk("rst_data", out_Data, 0);
        chk("rst_beat_count", beat_Count, 0);
        chk("rst_seq_err", seq_Err, 0);
        r_Rst = 1'b0;
        step();

        // ---- 1: async reset mid-beat discards partial words ----
        out_Ready = 1'b1;
        push_beat(8'h00, 8'h01, 8'h02, 8'h03);
        push(8'h04);
        push(8'h05);
        empty_gate = 1'b0;
        for (int k = 0; k < 40 && rd_ptr != 6'd5; k++) step();
        chk("t1_reach_pop5", rd_ptr, 5);
        chk("t1_r_inc_before", r_Inc, 1);
        chk("t1_beat_count_before", beat_Count, 1);
        chk("t1_data_before", out_Data, 32'h03020100);
        @(posedge r_Clk);
        #3;
        r_Rst = 1'b1;
        #1;
        chk("t1_async_r_inc", r_Inc, 0);
        chk("t1_async_valid", out_Valid, 0);
        chk("t1_async_data", out_Data, 0);
        chk("t1_async_beat_count", beat_Count, 0);
        push_beat(8'h06, 8'h07, 8'h08, 8'h09);
        step();
        step();
        r_Rst = 1'b0;
        wait_sb("t1_drain");
        step();
        chk("t1_beat_count", beat_Count, 1);

        // ---- 2: streaming, r_Inc high eight cycles ----
        do_reset();
        out_Ready = 1'b1;
        push_beat(8'h00, 8'h01, 8'h02, 8'h03);
        push_beat(8'h04, 8'h05, 8'h06, 8'h07);
        step();
        empty_gate = 1'b0;
        #1;
        chk("t2_r_inc_0", r_Inc, 1);
        for (int k = 1; k < 8; k++) begin
            step();
            chk($sformatf("t2_r_inc_%0d", k), r_Inc, 1);
        end
        step();
        chk("t2_r_inc_done", r_Inc, 0);
        chk("t2_valid2", out_Valid, 1);
        chk("t2_data2", out_Data, 32'h07060504);
        wait_sb("t2_drain");
        step();
        chk("t2_beat_count", beat_Count, 2);

        // ---- 3: back-pressure ----
        do_reset();
        out_Ready = 1'b0;
        push_beat(8'h00, 8'h01, 8'h02, 8'h03);
        push_beat(8'h04, 8'h05, 8'h06, 8'h07);
        r0 = rd_ptr;
        step();
        empty_gate = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 3; k++) begin
            chk("t3_r_inc_stall", r_Inc, 0);
            chk("t3_valid", out_Valid, 1);
            chk("t3_data_held", out_Data, 32'h03020100);
            chk("t3_pops_4", 6'(rd_ptr - r0), 4);
            step();
        end
        out_Ready = 1'b1;
        wait_sb("t3_drain");
        step();
        chk("t3_beat_count", beat_Count, 2);
        chk("t3_pops_8", 6'(rd_ptr - r0), 8);

        // ---- 4: gapped empty ----
        do_reset();
        out_Ready = 1'b1;
        push_beat(8'h00, 8'h01, 8'h02, 8'h03);
        r0 = rd_ptr;
        for (int i = 0; i < 4; i++) begin
            step();
            empty_gate = 1'b0;
            step();
            empty_gate = 1'b1;
            #1;
            chk("t4_gap_r_inc", r_Inc, 0);
            step();
            chk("t4_gap_r_inc2", r_Inc, 0);
            chk("t4_pops", 6'(rd_ptr - r0), 6'(i + 1));
            if (i < 3) chk("t4_no_valid", out_Valid, 0);
        end
        wait_sb("t4_drain");
        step();
        chk("t4_beat_count", beat_Count, 1);

        // ---- 5: flush discards partial beat ----
        do_reset();
        out_Ready = 1'b1;
        push(8'h00);
        push(8'h01);
        push_beat(8'h10, 8'h11, 8'h12, 8'h13);
        r0 = rd_ptr;
        step();
        empty_gate = 1'b0;
        step();
        step();
        flush = 1'b1;
        #1;
        chk("t5_flush_r_inc", r_Inc, 0);
        step();
        flush = 1'b0;
        chk("t5_pops_2", 6'(rd_ptr - r0), 2);
        wait_sb("t5_drain");
        step();
        chk("t5_beat_count", beat_Count, 1);
        chk("t5_pops_6", 6'(rd_ptr - r0), 6);

        // ---- 6: sequence check ----
        do_reset();
        out_Ready = 1'b1;
        push_beat(8'h00, 8'h01, 8'h03, 8'h04);
        step();
        empty_gate = 1'b0;
        step();
        chk("t6_seq_after_00", seq_Err, 0);
        step();
        chk("t6_seq_after_01", seq_Err, 0);
        step();
        chk("t6_seq_after_03", seq_Err, SE);
        step();
        chk("t6_seq_after_04", seq_Err, SE);
        step();
        chk("t6_seq_sticky", seq_Err, SE);
        wait_sb("t6_drain");

        chk("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
